// File: rtl/accel_sketch_pkg.sv
// Shared types and constants for the accelerometer capture path.
package accel_sketch_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  // Bit positions in irq_ack
  localparam int IRQ_HALF = 0;
  localparam int IRQ_FULL = 1;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/accel_sample_writer_if.sv
// Avalon-MM write-only master bus toward the sample memory s1 slave.
interface accel_sample_writer_if
  import accel_sketch_pkg::*;
#(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [WORD_W-1:0] m_writedata;
  logic              m_waitrequest;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata,
    input  m_waitrequest
  );

  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata,
    output m_waitrequest
  );
endinterface

// File: rtl/accel_sample_fifo.sv
// Small synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module accel_sample_fifo
  import accel_sketch_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= wdata;
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/accel_sample_writer.sv
// Circular-buffer capture engine: FIFO-buffered X/Y samples written as 32-bit words over Avalon-MM.
module accel_sample_writer
  import accel_sketch_pkg::*;
#(
  parameter int DEPTH      = 25000,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_x,
  input  logic [SAMPLE_W-1:0]   sample_y,
  accel_sample_writer_if.master avm,
  output logic [ADDR_W-1:0]     wr_ptr,
  output logic [15:0]           wrap_count,
  output logic [15:0]           drop_count,
  output logic                  irq_half,
  output logic                  irq_full,
  input  logic [1:0]            irq_ack
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(DEPTH / 2 - 1);

  state_t            state;
  logic [WORD_W-1:0] data_q;
  logic              wr_q;
  logic              clr_pend;

  logic [WORD_W-1:0] f_rdata;
  logic              f_full;
  logic              f_empty;
  logic              completing;
  logic              clear_apply;
  logic              pop;
  logic              push;
  logic              drop;
  logic [ADDR_W-1:0] ptr_next;

  // Clear takes effect at once in IDLE, otherwise only in the cycle the in-flight write completes
  assign completing  = (state == WRITE) && !avm.m_waitrequest;
  assign clear_apply = ((state == IDLE) && clear) || (completing && (clear || clr_pend));
  assign pop         = !clear_apply && !f_empty && ((state == IDLE) || completing);
  assign push        = sample_valid && enable && !clear_apply;
  assign drop        = push && f_full && !pop;
  assign ptr_next    = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;

  accel_sample_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear_apply),
    .push  (push),
    .pop   (pop),
    .wdata ({sample_y, sample_x}),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  assign avm.m_address    = wr_ptr;
  assign avm.m_write      = wr_q;
  assign avm.m_chipselect = wr_q;
  assign avm.m_byteenable = {4{wr_q}};
  assign avm.m_writedata  = data_q;

  // Write FSM with data register, pointer, counters and sticky IRQ flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_q     <= '0;
      wr_q       <= 1'b0;
      clr_pend   <= 1'b0;
      wr_ptr     <= '0;
      wrap_count <= '0;
      drop_count <= '0;
      irq_half   <= 1'b0;
      irq_full   <= 1'b0;
    end else if (clear_apply) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      clr_pend   <= 1'b0;
      wr_ptr     <= '0;
      wrap_count <= '0;
      drop_count <= '0;
      irq_half   <= 1'b0;
      irq_full   <= 1'b0;
    end else begin
      if (drop) drop_count <= sat_inc16(drop_count);
      // Ack first so a same-cycle set below overrides it
      if (irq_ack[IRQ_HALF]) irq_half <= 1'b0;
      if (irq_ack[IRQ_FULL]) irq_full <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            data_q <= f_rdata;
            wr_q   <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (clear) clr_pend <= 1'b1;
          if (completing) begin
            wr_ptr <= ptr_next;
            if (wr_ptr == LAST) begin
              wrap_count <= sat_inc16(wrap_count);
              irq_full   <= 1'b1;
            end
            if (wr_ptr == HALF) irq_half <= 1'b1;
            if (pop) begin
              data_q <= f_rdata;
            end else begin
              wr_q  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accel_sample_writer.sv
// Directed self-checking bench for accel_sample_writer (small ring of 8 words).
module tb_accel_sample_writer;
  import accel_sketch_pkg::*;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              clear = 1'b0;
  logic              sample_valid = 1'b0;
  logic [15:0]       sample_x = '0;
  logic [15:0]       sample_y = '0;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       wrap_count;
  logic [15:0]       drop_count;
  logic              irq_half;
  logic              irq_full;
  logic [1:0]        irq_ack = '0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  accel_sample_writer_if #(.ADDR_W(ADDR_W)) avm ();

  accel_sample_writer #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .avm          (avm),
    .wr_ptr       (wr_ptr),
    .wrap_count   (wrap_count),
    .drop_count   (drop_count),
    .irq_half     (irq_half),
    .irq_full     (irq_full),
    .irq_ack      (irq_ack)
  );

  always #5 clk = ~clk;

  // Record every completed transfer, observed mid-cycle
  always @(negedge clk) begin
    if (!reset && avm.m_write && !avm.m_waitrequest) begin
      wa_q.push_back(avm.m_address);
      wd_q.push_back(avm.m_writedata);
    end
  end

  function automatic logic [15:0] sx(input int i);
    return 16'(32'h1000 + i);
  endfunction

  function automatic logic [15:0] sy(input int i);
    return 16'(32'hF000 + i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    clear = 1'b0;
    sample_valid = 1'b0;
    irq_ack = '0;
    avm.m_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y);
    sample_valid = 1'b1;
    sample_x = x;
    sample_y = y;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send(input int n, input int base);
    for (int i = 0; i < n; i++) push(sx(base + i), sy(base + i));
    repeat (n + 3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({avm.m_write, avm.m_chipselect, avm.m_byteenable} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000000", {avm.m_write, avm.m_chipselect, avm.m_byteenable});
    end
    tests_run++;
    if ({avm.m_address, avm.m_writedata, wr_ptr, wrap_count, drop_count, irq_half, irq_full} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: addr %h data %h ptr %h wrap %h drop %h irq %b%b expected all zero",
               avm.m_address, avm.m_writedata, wr_ptr, wrap_count, drop_count, irq_full, irq_half);
    end
  endtask

  task automatic test_single();
    do_reset();
    push(16'h1234, 16'hABCD);
    tests_run++;
    if (avm.m_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_t1: m_write %b expected 0", avm.m_write);
    end
    tick();
    tests_run++;
    if ({avm.m_write, avm.m_chipselect, avm.m_byteenable, avm.m_address, avm.m_writedata}
        !== {1'b1, 1'b1, 4'hF, 3'd0, 32'hABCD1234}) begin
      tests_failed++;
      $display("FAIL single_t2: wr %b cs %b be %h addr %h data %h expected 1 1 f 0 abcd1234",
               avm.m_write, avm.m_chipselect, avm.m_byteenable, avm.m_address, avm.m_writedata);
    end
    tick();
    tests_run++;
    if ({avm.m_write, avm.m_byteenable, wr_ptr} !== {1'b0, 4'h0, 3'd1}) begin
      tests_failed++;
      $display("FAIL single_done: wr %b be %h ptr %0d expected 0 0 1", avm.m_write, avm.m_byteenable, wr_ptr);
    end
  endtask

  task automatic test_stall_drop();
    do_reset();
    avm.m_waitrequest = 1'b1;
    for (int i = 1; i <= 6; i++) push(sx(i), sy(i));
    repeat (4) tick();
    tests_run++;
    if ({drop_count, avm.m_write, avm.m_address, avm.m_writedata} !== {16'd1, 1'b1, 3'd0, sy(1), sx(1)}) begin
      tests_failed++;
      $display("FAIL stall_hold: drop %0d wr %b addr %h data %h expected 1 1 0 %h%h",
               drop_count, avm.m_write, avm.m_address, avm.m_writedata, sy(1), sx(1));
    end
    avm.m_waitrequest = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (wa_q.size() != 5 || avm.m_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_drain: %0d writes wr %b expected 5 writes wr 0", wa_q.size(), avm.m_write);
    end
    for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
      tests_run++;
      if ({wa_q[i], wd_q[i]} !== {3'(i), sy(i + 1), sx(i + 1)}) begin
        tests_failed++;
        $display("FAIL stall_word%0d: addr %h data %h expected %h %h%h",
                 i, wa_q[i], wd_q[i], 3'(i), sy(i + 1), sx(i + 1));
      end
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    avm.m_waitrequest = 1'b1;
    for (int i = 1; i <= 5; i++) push(sx(i), sy(i));
    avm.m_waitrequest = 1'b0;
    push(sx(6), sy(6));
    repeat (5) tick();
    tests_run++;
    if ({drop_count, wr_ptr, avm.m_write} !== {16'd0, 3'd6, 1'b0} || wd_q.size() != 6) begin
      tests_failed++;
      $display("FAIL full_pushpop: drop %0d ptr %0d wr %b writes %0d expected 0 6 0 6",
               drop_count, wr_ptr, avm.m_write, wd_q.size());
    end else begin
      tests_run++;
      if (wd_q[5] !== {sy(6), sx(6)}) begin
        tests_failed++;
        $display("FAIL full_pushpop_data: got %h expected %h%h", wd_q[5], sy(6), sx(6));
      end
    end
  endtask

  task automatic test_wrap_irq();
    do_reset();
    send(3, 1);
    tests_run++;
    if ({irq_half, irq_full, wr_ptr} !== {1'b0, 1'b0, 3'd3}) begin
      tests_failed++;
      $display("FAIL irq_before_half: half %b full %b ptr %0d expected 0 0 3", irq_half, irq_full, wr_ptr);
    end
    send(1, 4);
    tests_run++;
    if ({irq_half, irq_full} !== 2'b10) begin
      tests_failed++;
      $display("FAIL irq_half_set: half %b full %b expected 1 0", irq_half, irq_full);
    end
    send(4, 5);
    tests_run++;
    if ({irq_half, irq_full, wrap_count, wr_ptr} !== {1'b1, 1'b1, 16'd1, 3'd0}) begin
      tests_failed++;
      $display("FAIL irq_full_wrap: half %b full %b wrap %0d ptr %0d expected 1 1 1 0",
               irq_half, irq_full, wrap_count, wr_ptr);
    end
    send(1, 9);
    tests_run++;
    if (wa_q.size() != 9 || wr_ptr !== 3'd1) begin
      tests_failed++;
      $display("FAIL wrap_ninth: writes %0d ptr %0d expected 9 1", wa_q.size(), wr_ptr);
    end else begin
      tests_run++;
      if ({wa_q[8], wd_q[8]} !== {3'd0, sy(9), sx(9)}) begin
        tests_failed++;
        $display("FAIL wrap_ninth_word: addr %h data %h expected 0 %h%h", wa_q[8], wd_q[8], sy(9), sx(9));
      end
    end
    irq_ack = 2'b01;
    tick();
    irq_ack = 2'b00;
    tests_run++;
    if ({irq_half, irq_full} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ack_half: half %b full %b expected 0 1", irq_half, irq_full);
    end
    irq_ack = 2'b10;
    tick();
    irq_ack = 2'b00;
    tests_run++;
    if ({irq_half, irq_full} !== 2'b00) begin
      tests_failed++;
      $display("FAIL ack_full: half %b full %b expected 0 0", irq_half, irq_full);
    end
  endtask

  task automatic test_clear_stall();
    do_reset();
    send(4, 1);
    avm.m_waitrequest = 1'b1;
    for (int i = 11; i <= 16; i++) push(sx(i), sy(i));
    tests_run++;
    if ({drop_count, irq_half, wr_ptr} !== {16'd1, 1'b1, 3'd4}) begin
      tests_failed++;
      $display("FAIL clear_pre: drop %0d half %b ptr %0d expected 1 1 4", drop_count, irq_half, wr_ptr);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (2) tick();
    tests_run++;
    if ({avm.m_write, avm.m_byteenable, avm.m_address, avm.m_writedata, drop_count}
        !== {1'b1, 4'hF, 3'd4, sy(11), sx(11), 16'd1}) begin
      tests_failed++;
      $display("FAIL clear_hold: wr %b be %h addr %h data %h drop %0d expected 1 f 4 %h%h 1",
               avm.m_write, avm.m_byteenable, avm.m_address, avm.m_writedata, drop_count, sy(11), sx(11));
    end
    avm.m_waitrequest = 1'b0;
    tick();
    tests_run++;
    if ({avm.m_write, wr_ptr, drop_count, wrap_count, irq_half, irq_full} !== '0) begin
      tests_failed++;
      $display("FAIL clear_applied: wr %b ptr %0d drop %0d wrap %0d half %b full %b expected all 0",
               avm.m_write, wr_ptr, drop_count, wrap_count, irq_half, irq_full);
    end
    repeat (3) tick();
    tests_run++;
    if (avm.m_write !== 1'b0 || wa_q.size() != 5) begin
      tests_failed++;
      $display("FAIL clear_flushed: wr %b writes %0d expected 0 5", avm.m_write, wa_q.size());
    end
  endtask

  task automatic test_enable();
    do_reset();
    avm.m_waitrequest = 1'b1;
    for (int i = 1; i <= 3; i++) push(sx(i), sy(i));
    enable = 1'b0;
    avm.m_waitrequest = 1'b0;
    for (int i = 4; i <= 9; i++) push(sx(i), sy(i));
    repeat (4) tick();
    tests_run++;
    if (wa_q.size() != 3 || {drop_count, wr_ptr, avm.m_write} !== {16'd0, 3'd3, 1'b0}) begin
      tests_failed++;
      $display("FAIL enable_low: writes %0d drop %0d ptr %0d wr %b expected 3 0 3 0",
               wa_q.size(), drop_count, wr_ptr, avm.m_write);
    end else begin
      tests_run++;
      if (wd_q[2] !== {sy(3), sx(3)}) begin
        tests_failed++;
        $display("FAIL enable_low_data: got %h expected %h%h", wd_q[2], sy(3), sx(3));
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    avm.m_waitrequest = 1'b1;
    push(sx(1), sy(1));
    tick();
    tests_run++;
    if (avm.m_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre: wr %b expected 1", avm.m_write);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({avm.m_write, avm.m_chipselect, avm.m_byteenable, avm.m_writedata, wr_ptr} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_async: wr %b cs %b be %h data %h ptr %0d expected all 0",
               avm.m_write, avm.m_chipselect, avm.m_byteenable, avm.m_writedata, wr_ptr);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    avm.m_waitrequest = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (avm.m_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_after: wr %b expected 0", avm.m_write);
    end
  endtask

  initial begin
    avm.m_waitrequest = 1'b0;
    test_reset();
    test_single();
    test_stall_drop();
    test_push_pop_full();
    test_wrap_irq();
    test_clear_stall();
    test_enable();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/accel_sample_writer.md
# accel_sample_writer

Circular-buffer capture engine that sits directly upstream of the 25000-word on-chip sample memory. It accepts 16-bit X/Y accelerometer sample pairs from the SPI sampler as single-cycle strobes, which cannot be back-pressured. It buffers them in a small FIFO and writes each pair as one 32-bit word through an Avalon-MM write master into the memory's s1 slave. It tracks the write pointer, wrap-arounds and dropped samples, and raises half/full interrupts for the Nios II consumer.

## Interface
- DEPTH, 25000, number of 32-bit words in the target memory (ring size)
- ADDR_W, 15, word-address width, must satisfy 2**ADDR_W >= DEPTH
- FIFO_DEPTH, 4, sample FIFO entries, power of 2, >= 2
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; when low, new samples are ignored and not counted as drops
- clear  in  1  single-cycle pulse; flushes and zeroes all state
- sample_valid  in  1  one-cycle strobe qualifying sample_x/sample_y
- sample_x  in  16  X sample, two's complement
- sample_y  in  16  Y sample, two's complement
- m_address  out  ADDR_W  word address
- m_byteenable  out  4  always 4'hF while writing, else 4'h0
- m_chipselect  out  1  asserted together with m_write
- m_write  out  1  write request
- m_writedata  out  32  {sample_y, sample_x}
- m_waitrequest  in  1  fabric stall; transfer completes in a cycle where m_write=1 and m_waitrequest=0
- wr_ptr  out  ADDR_W  next word address to be written
- wrap_count  out  16  completed ring wraps, saturating at 16'hFFFF
- drop_count  out  16  samples lost to a full FIFO, saturating at 16'hFFFF
- irq_half  out  1  sticky; set when the word at DEPTH/2-1 completes
- irq_full  out  1  sticky; set when the word at DEPTH-1 completes
- irq_ack  in  2  bit0 clears irq_half, bit1 clears irq_full

## Operation
- Push: sample_valid & enable & (not full, or pop in the same cycle) pushes {y,x}. sample_valid & enable & full & no pop increments drop_count.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the data register, go to WRITE.
  - WRITE: m_chipselect = m_write = 1; m_address = wr_ptr; m_writedata = data register. All master outputs are held stable while m_waitrequest = 1.
  - WRITE completion: wr_ptr advances. If the FIFO is non-empty, pop the next sample and stay in WRITE. Otherwise go to IDLE.
- Pointer: wr_ptr = DEPTH-1 on completion → 0, and wrap_count increments (saturating).
- IRQ: set on completion at DEPTH/2-1 (integer division) or DEPTH-1. Same-cycle set and ack → set wins.
- clear in IDLE: applied immediately. FIFO, wr_ptr, wrap_count, drop_count, irq_* → 0.
- clear in WRITE: latched as pending. The in-flight transfer completes normally; no Avalon abort. In the completion cycle, clear is applied instead of the pointer advance and pop, and the FSM goes to IDLE.
- enable low: push stops; the FIFO keeps draining to memory.

## Timing
- Reset values: all outputs 0 (m_byteenable = 4'h0), FSM in IDLE, FIFO empty, clear-pending = 0.
- Latency: sample_valid at cycle t with FIFO empty and FSM in IDLE → m_write = 1 at t+2.
- Throughput: 1 word/cycle with m_waitrequest = 0. There is no idle cycle between back-to-back writes.
- A push and a pop when full in the same cycle are both accepted; count stays at FIFO_DEPTH and there is no drop.
- All outputs are registered except that the master outputs come from the FSM/data registers directly; there is no combinational path from sample_* to m_*.

## Structure
- Shared package accel_sketch_pkg: FSM state enum (IDLE, WRITE), SAMPLE_W = 16, WORD_W = 32, IRQ bit indices.
- Sub-module accel_sample_fifo: synchronous FIFO, WORD_W × FIFO_DEPTH. Provides push/pop/full/empty/flush with a registered count. The same-cycle push-when-full-with-pop rule is implemented inside it.
- Top: FSM, data register, pointer/wrap/drop counters, IRQ flags, clear-pending flag.

## Test plan
- Single sample x=16'h1234, y=16'hABCD after reset, waitrequest = 0 → m_write high at t+2, address 0, data 32'hABCD1234; wr_ptr = 1 after completion.
- 6 consecutive strobes with m_waitrequest held high for 10 cycles → FIFO fills to 4 plus one word in flight, drop_count = 1. After release, 5 words are written to addresses 0..4 in order.
- With DEPTH = 8, write 9 samples → the 9th word goes to address 0, wrap_count = 1. irq_half is set after address 3, irq_full after address 7. irq_ack = 2'b01 clears only irq_half.
- clear asserted while WRITE is stalled by m_waitrequest → outputs stay stable until waitrequest drops. Then wr_ptr = 0, counters = 0, FIFO empty, FSM in IDLE.
- enable low with 3 samples queued → all 3 are written, and further strobes neither write nor increment drop_count.
- reset asserted mid-WRITE → m_write/m_chipselect drop immediately (asynchronous), all outputs return to 0.
